// File: rtl/body_code_rx_pkg.sv
// Shared definitions for the body-code serial receiver: FSM state encoding,
// frame length constants and the default inter-strobe timeout.
// Optional feature macro: BODY_PARITY_CHECK_EN (adds an even-parity bit).
package body_code_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int DATA_BITS       = 3;
  localparam logic [1:0] LAST_BIT = 2'd2;
  localparam int DEFAULT_TIMEOUT = 8;

`ifdef BODY_PARITY_CHECK_EN
  localparam int FRAME_BITS = 6;
`else
  localparam int FRAME_BITS = 5;
`endif

  // Even parity holds when data and parity bit together have an even count of ones.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

endpackage

// File: rtl/body_code_rx_if.sv
// Bundle of the serial input, the code handshake and the status flags.
// Handshake: code is transferred on every rising edge where code_valid=1 and
// code_ready=1; while code_valid=1 and code_ready=0 the producer holds code
// stable, and code_valid never drops without a transfer (except on reset).
interface body_code_rx_if;
  import body_code_rx_pkg::*;

  logic                 rx_en;
  logic                 rx_bit;
  logic                 code_ready;
  logic [DATA_BITS-1:0] code;
  logic                 code_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  state_t               dbg_state;

  modport master (
    output rx_en, rx_bit, code_ready,
    input  code, code_valid, frame_err, overrun, busy, dbg_state
  );

  modport slave (
    input  rx_en, rx_bit, code_ready,
    output code, code_valid, frame_err, overrun, busy, dbg_state
  );
endinterface

// File: rtl/body_code_buf.sv
// One-entry output buffer for received codes. A new code is accepted when the
// buffer is empty or is being drained in the same cycle; otherwise it is
// dropped and the sticky overrun flag is raised.
module body_code_buf
  import body_code_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 deliver,
  input  logic [DATA_BITS-1:0] new_code,
  input  logic                 code_ready,
  output logic [DATA_BITS-1:0] code,
  output logic                 code_valid,
  output logic                 overrun
);

  logic take;
  assign take = code_valid && code_ready;

  // Buffer fill/drain and overrun tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver) begin
      if (!code_valid || code_ready) begin
        code       <= new_code;
        code_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (take) begin
      code_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/body_code_rx.sv
// Serial receiver for 3-bit body codes: start(1), d2 d1 d0, [parity], stop(0).
// Bits are taken only on rx_en strobes; a stall of TIMEOUT cycles without a
// strobe inside a frame aborts it. Define BODY_PARITY_CHECK_EN to add the
// even-parity bit between the data and the stop bit.
module body_code_rx
  import body_code_rx_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  body_code_rx_if.slave  bus
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

`ifdef BODY_PARITY_CHECK_EN
  localparam state_t AFTER_DATA = ST_PARITY;
`else
  localparam state_t AFTER_DATA = ST_STOP;
`endif

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           bit_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 frame_err_q;
  logic                 deliver;

  // A good stop bit hands the assembled code to the buffer on this same edge.
  assign deliver = (state == ST_STOP) && bus.rx_en && !bus.rx_bit;

  // Frame FSM, shift register and gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;

      // Stall watchdog: only strobe-free cycles inside a frame are counted.
      if (state == ST_IDLE || bus.rx_en) begin
        gap_cnt <= '0;
      end else if (gap_cnt == GAP_LAST) begin
        gap_cnt     <= '0;
        frame_err_q <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end

      if (bus.rx_en) begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_bit) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg <= {shreg[DATA_BITS-2:0], bus.rx_bit};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= AFTER_DATA;
            end else begin
              bit_cnt <= bit_cnt + 2'd1;
            end
          end
`ifdef BODY_PARITY_CHECK_EN
          ST_PARITY: begin
            if (parity_ok(shreg, bus.rx_bit)) begin
              state <= ST_STOP;
            end else begin
              frame_err_q <= 1'b1;
              state       <= ST_IDLE;
            end
          end
`endif
          ST_STOP: begin
            frame_err_q <= bus.rx_bit;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  body_code_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .deliver    (deliver),
    .new_code   (shreg),
    .code_ready (bus.code_ready),
    .code       (bus.code),
    .code_valid (bus.code_valid),
    .overrun    (bus.overrun)
  );

  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.dbg_state = state;

endmodule

// File: doc/body_code_rx.md
BODY_CODE_RX -- requirements
Module: body_code_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, meaning the maximum number of consecutive cycles without rx_en allowed inside a frame.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port rx_en, input, 1, bit strobe; rx_bit is sampled only on cycles where rx_en=1.
REQ-005 SHALL have port rx_bit, input, 1, the serial line data.
REQ-006 SHALL have port code_ready, input, 1, downstream (type_of_body consumer) accepts the code.
REQ-007 SHALL have port code, output, 3, the assembled body code, fed directly to type_of_body.code.
REQ-008 SHALL have port code_valid, output, 1, code holds an unconsumed frame.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit, parity error or timeout.
REQ-010 SHALL have port overrun, output, 1, sticky flag: a good frame was dropped because the buffer was full.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 The frame format SHALL be: start bit 1, then data bits d2 d1 d0 (MSB first), then an optional parity bit, then stop bit 0, each taken on one rx_en strobe.
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP; DATA SHALL use a 2-bit bit counter from 0 to 2.
REQ-014 IDLE SHALL go to DATA on rx_en with rx_bit=1; rx_en with rx_bit=0 in IDLE SHALL be ignored.
REQ-015 DATA SHALL shift each strobed bit into a 3-bit shift register and, after the third bit, go to PARITY (macro defined) or to STOP.
REQ-016 PARITY SHALL check the even parity of d2^d1^d0^p; a mismatch SHALL pulse frame_err and return to IDLE with no code delivered.
REQ-017 STOP with rx_bit=0 SHALL deliver the frame; rx_bit=1 SHALL pulse frame_err; both cases SHALL return to IDLE.
REQ-018 code and code_valid SHALL update on the clock edge that samples a good stop bit, giving 1 cycle of latency from the stop strobe.
REQ-019 The output buffer SHALL hold one entry: code_valid stays high and code stays stable until a cycle with code_valid=1 and code_ready=1, after which code_valid clears.
REQ-020 If delivery and code_ready occur in the same cycle, the new code SHALL replace the buffer, code_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-021 If delivery occurs while the buffer is full and code_ready=0, the new code SHALL be discarded and overrun SHALL be set; the buffered code SHALL be unchanged.
REQ-022 A gap counter SHALL count cycles with rx_en=0 while not in IDLE and SHALL reset on every rx_en.
REQ-023 When the gap counter reaches TIMEOUT, the block SHALL pulse frame_err and return to IDLE, discarding the partial frame.
REQ-024 overrun SHALL clear only on reset.
REQ-025 The frame FSM and the output buffer SHALL operate independently, so reception continues while the buffer is full.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, shift register=0, code=3'b000, code_valid=0, frame_err=0, overrun=0, busy=0, gap counter=0.
REQ-027 rst SHALL take priority over every other input, and a frame that is in progress SHALL be abandoned with no frame_err pulse.

Configuration
REQ-028 Macro BODY_PARITY_CHECK_EN defined SHALL include the PARITY state and the even-parity check, giving 6-bit frames.
REQ-029 Macro BODY_PARITY_CHECK_EN undefined SHALL remove the PARITY state so that DATA goes straight to STOP, giving 5-bit frames.

Structure
REQ-030 A shared package/header SHALL hold the state encodings, the frame length constants and the default TIMEOUT.
REQ-031 The output buffer (code/code_valid/overrun) SHALL be a sub-module named body_code_buf; the FSM, shift register and gap counter SHALL stay in body_code_rx.

Verification
REQ-032 Macro off, strobes 1,1,0,0,0 with code_ready=1 -> code=3'b100 and code_valid pulses 1 cycle after the stop strobe.
REQ-033 Macro on, strobes 1,1,1,1,1,0 (parity 1 is even) -> code=3'b111 delivered; strobes 1,1,1,1,0,0 -> frame_err pulse and no delivery.
REQ-034 Two good frames 3'b001 then 3'b100 with code_ready=0 -> code stays 3'b001 and overrun=1; then code_ready=1 for 1 cycle -> code_valid=0.
REQ-035 Start bit plus 1 data bit, then 8 idle cycles (TIMEOUT=8) -> frame_err pulse on the 8th idle cycle and busy=0 on the next cycle.
REQ-036 rst asserted mid-DATA -> every output equals its reset value next cycle, no frame_err pulse, and a following frame 3'b001 is received correctly.
REQ-037 Stop strobe coincident with code_ready=1 while code_valid=1 -> buffer holds the new code, code_valid=1 and overrun=0.
